// File: rtl/stack_node_pkg.sv
// Shared constants for the stack node: port count, FSM encoding, size defaults.
package stack_node_pkg;

   localparam int unsigned NumPorts     = 4;
   localparam int unsigned WDefault     = 8;
   localparam int unsigned DepthDefault = 15;

   // Read-side FSM encoding
   localparam logic [1:0] StEmpty = 2'd0;
   localparam logic [1:0] StOffer = 2'd1;
   localparam logic [1:0] StCheck = 2'd2;

endpackage

// File: rtl/stack_node_stack_mem.sv
// LIFO storage for the stack node. Push and pop in the same cycle replace the top.
module stack_mem
   import stack_node_pkg::*;
#(
   parameter int unsigned W     = WDefault,
   parameter int unsigned DEPTH = DepthDefault
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic                           pop,
   input  logic [W-1:0]                   wdata,
   output logic [W-1:0]                   top,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full,
   output logic                           empty
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [CW-1:0] count_q;
   logic [AW-1:0] top_idx;
   logic [AW-1:0] wr_idx;
   logic          do_pop;
   logic          do_push;

   // Occupancy flags, top-of-stack read and write index selection
   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == CW'(DEPTH));
      do_pop  = pop && !empty;
      // A push at full is only legal when it replaces the popped top
      do_push = push && (do_pop || !full);
      top_idx = AW'(count_q - 1'b1);
      wr_idx  = do_pop ? top_idx : AW'(count_q);
      top     = empty ? '0 : mem_q[top_idx];
   end

   // Storage array; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_idx] <= wdata;
      end
   end

   // Stack pointer; unchanged on a simultaneous push and pop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (do_push && !do_pop) begin
         count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/stack_node.sv
// Four-port LIFO responder: push arbitration on the write half, round-robin
// offer/check read FSM on the read half.
module stack_node
   import stack_node_pkg::*;
#(
   parameter int unsigned W     = WDefault,
   parameter int unsigned DEPTH = DepthDefault
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [W-1:0]               wdata0,
   input  logic [W-1:0]               wdata1,
   input  logic [W-1:0]               wdata2,
   input  logic [W-1:0]               wdata3,
   input  logic                       wval0,
   input  logic                       wval1,
   input  logic                       wval2,
   input  logic                       wval3,
   output logic                       wresp0,
   output logic                       wresp1,
   output logic                       wresp2,
   output logic                       wresp3,
   output logic [W-1:0]               rdata0,
   output logic [W-1:0]               rdata1,
   output logic [W-1:0]               rdata2,
   output logic [W-1:0]               rdata3,
   output logic                       rrdy0,
   output logic                       rrdy1,
   output logic                       rrdy2,
   output logic                       rrdy3,
   input  logic                       rresp0,
   input  logic                       rresp1,
   input  logic                       rresp2,
   input  logic                       rresp3,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [NumPorts-1:0] wval;
   logic [NumPorts-1:0] rresp;
   logic [W-1:0]        wdata_arr [NumPorts];
   logic [NumPorts-1:0] eligible;
   logic [NumPorts-1:0] grant;
   logic [NumPorts-1:0] wresp_q, wresp_d;
   logic [NumPorts-1:0] rrdy_vec;
   logic [1:0]          state_q, state_d;
   logic [1:0]          p_q, p_d;
   logic [W-1:0]        push_data;
   logic [W-1:0]        top;
   logic [CW:0]         count_after;
   logic                found;
   logic                push;
   logic                pop;
   logic                full;
   logic                empty;

   assign wval         = {wval3, wval2, wval1, wval0};
   assign rresp        = {rresp3, rresp2, rresp1, rresp0};
   assign wdata_arr[0] = wdata0;
   assign wdata_arr[1] = wdata1;
   assign wdata_arr[2] = wdata2;
   assign wdata_arr[3] = wdata3;

   stack_mem #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_stack_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (push_data),
      .top   (top),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Push arbitration: lowest eligible index wins; a port with wresp high sits out
   always_comb begin
      eligible  = wval & ~wresp_q;
      grant     = '0;
      push_data = '0;
      found     = 1'b0;
      for (int i = 0; i < NumPorts; i++) begin
         if (eligible[i] && !found) begin
            found     = 1'b1;
            grant[i]  = 1'b1;
            push_data = wdata_arr[i];
         end
      end
      // rresp only counts for the port offered in the preceding cycle
      pop     = (state_q == StCheck) && rresp[p_q] && !empty;
      push    = (state_q != StOffer) && (!full || pop) && found;
      wresp_d = push ? grant : '0;
   end

   // Read FSM next state and round-robin pointer advance
   always_comb begin
      count_after = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
      state_d     = state_q;
      p_d         = p_q;
      case (state_q)
         StEmpty: if (push) state_d = StOffer;
         StOffer: state_d = StCheck;
         StCheck: begin
            p_d     = p_q + 2'd1;
            state_d = (count_after != '0) ? StOffer : StEmpty;
         end
         default: state_d = StEmpty;
      endcase
   end

   // FSM, pointer and push-acknowledge registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         p_q     <= 2'd0;
         wresp_q <= '0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         wresp_q <= wresp_d;
      end
   end

   // Read offer decoded purely from registered state
   always_comb begin
      rrdy_vec = '0;
      if (state_q == StOffer) begin
         rrdy_vec[p_q] = 1'b1;
      end
   end

   assign rrdy0  = rrdy_vec[0];
   assign rrdy1  = rrdy_vec[1];
   assign rrdy2  = rrdy_vec[2];
   assign rrdy3  = rrdy_vec[3];
   assign rdata0 = rrdy_vec[0] ? top : '0;
   assign rdata1 = rrdy_vec[1] ? top : '0;
   assign rdata2 = rrdy_vec[2] ? top : '0;
   assign rdata3 = rrdy_vec[3] ? top : '0;
   assign wresp0 = wresp_q[0];
   assign wresp1 = wresp_q[1];
   assign wresp2 = wresp_q[2];
   assign wresp3 = wresp_q[3];

endmodule
